// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the RISC-V load/store size encodings, the responder state type and
// the legality check for a funct3/direction pair.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Unused encodings are never legal; unsigned variants only make sense for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad_enc;
        bad_enc = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return bad_enc || (we && f3[2]);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one data-memory access.
// Ports:
//   addr_lo   - byte offset within the word (addr[1:0])
//   funct3    - RISC-V size/sign code
//   wdata     - right-justified store data
//   rword     - raw RAM word at the addressed index
//   be        - per-byte write enables for a store
//   wword     - store data replicated onto every lane it may occupy
//   rdata_ext - extracted and sign/zero-extended load data
//   misalign  - half/word access not on its natural boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be        = 4'b0000;
        wword     = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        byte_s    = rword[{addr_lo, 3'b000} +: 8];
        half_s    = rword[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wword     = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, byte_s} : 32'(byte_s);
            end
            F3_H, F3_HU: begin
                misalign  = addr_lo[0];
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'b0, half_s} : 32'(half_s);
            end
            F3_W: begin
                misalign  = |addr_lo;
                be        = 4'b1111;
                wword     = wdata;
                rdata_ext = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with a fixed, programmable access latency.
// Ports:
//   clk, reset_l            - clock, synchronous active-low reset
//   req_valid/req_ready     - request handshake (one outstanding request)
//   req_we, req_addr,
//   req_funct3, req_wdata   - store/load, byte address, size code, store data
//   rsp_valid/rsp_ready     - response handshake
//   rsp_rdata, rsp_err      - extended load data (0 for stores/errors), reject flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t state, state_nxt;
    logic [3:0] cnt;

    logic [31:0] mem [DEPTH];

    logic        we_p0;
    logic [31:0] addr_p0;
    logic [2:0]  f3_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;
    logic        err_p1;

    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        out_of_range;
    logic        err;
    logic        accept;
    logic        access;

    assign idx          = addr_p0[ADDR_WIDTH+1:2];
    assign out_of_range = |(addr_p0 >> (ADDR_WIDTH + 2));
    assign err          = f3_illegal(f3_p0, we_p0) || misalign || out_of_range;

    // Outputs are qualified by reset_l so they read 0 for the whole reset cycle,
    // not just after the following edge.
    assign req_ready = reset_l && (state == IDLE);
    assign rsp_valid = reset_l && (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_p1 : '0;
    assign rsp_err   = rsp_valid && err_p1;

    assign accept = req_valid && req_ready;
    assign access = reset_l && (state == WAIT) && (cnt == 4'd0);

    dmem_lane_align u_align (
        .addr_lo   (addr_p0[1:0]),
        .funct3    (f3_p0),
        .wdata     (wdata_p0),
        .rword     (mem[idx]),
        .be        (be),
        .wword     (wword),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request captured at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            f3_p0    <= req_funct3;
            wdata_p0 <= req_wdata;
        end
    end

    // p1: access performed on the last WAIT edge
    always_ff @(posedge clk) begin
        if (access) begin
            rdata_p1 <= (err || we_p0) ? '0 : rdata_ext;
            err_p1   <= err;
        end
    end

    // Store commit is gated by access, which already excludes a reset cycle,
    // so a store interrupted by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (access && we_p0 && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_l;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance, LATENCY 4
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    // second instance, LATENCY 1
    logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic [2:0]  req_funct31;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_l(reset_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_l(reset_l),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_funct3(req_funct31), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic prev_vld = 1'b0;

    // Response monitor: latency on rise, data/err on handshake
    always @(negedge clk) begin
        if (rsp_valid && !prev_vld) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else chk({sb[0].tag, "_lat"}, 32'(cyc - sb[0].acc), 32'(LAT));
        end
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_rdata"}, rsp_rdata, e.rd);
            chk({e.tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
        end
        prev_vld = rsp_valid;
    end

    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input bit track);
        int n;
        exp_t e;
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk({tag, "_accept_tmo"}, 32'd0, 32'd1);
                break;
            end
        end
        if (track) begin
            e.tag = tag; e.rd = exp_rd; e.err = exp_err; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #2;
        // scramble inputs after acceptance: the DUT must use its captured copy
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_tmo", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk); #2;
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        issue(tag, we, f3, addr, wd, exp_rd, exp_err, 1'b1);
        wait_done();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
    endtask

    // LATENCY 1 instance: rsp_valid must be low one edge after acceptance... no,
    // it must rise exactly at the first edge after acceptance.
    task automatic xact1(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
        @(posedge clk); #2;
        req_valid1 = 1'b1; req_we1 = we; req_funct31 = f3; req_addr1 = addr; req_wdata1 = wd;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, req_ready1}, 32'd1);
        chk({tag, "_pre_valid"}, {31'b0, rsp_valid1}, 32'd0);
        @(posedge clk); #2;   // accepted at that edge
        req_valid1 = 1'b0; req_addr1 = $urandom; req_wdata1 = $urandom;
        @(posedge clk); #2;   // one edge later: response up
        chk({tag, "_valid"}, {31'b0, rsp_valid1}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata1, exp_rd);
        chk({tag, "_err"}, {31'b0, rsp_err1}, 32'd0);
        @(posedge clk); #2;   // handshake taken
        chk({tag, "_drop"}, {31'b0, rsp_valid1}, 32'd0);
    endtask

    initial begin
        reset_l = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_funct31 = '0;
        rsp_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst0");
        @(posedge clk); #2;
        reset_l = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);

        // word round trip and extension
        xact("sw_10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw_10",  1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("lb_13",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        xact("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        xact("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        xact("lb_10",  1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);

        // errors
        xact("lw_12_mis",  1'b0, F3_W,   32'h12,   32'h0,    32'h0, 1'b1);
        xact("sh_11_mis",  1'b1, F3_H,   32'h11,   32'hFFFF, 32'h0, 1'b1);
        xact("lw_10_keep", 1'b0, F3_W,   32'h10,   32'h0,    32'hDEADBEEF, 1'b0);
        xact("lw_oor",     1'b0, F3_W,   32'h1000, 32'h0,    32'h0, 1'b1);
        xact("f3_011",     1'b0, 3'b011, 32'h10,   32'h0,    32'h0, 1'b1);
        xact("sbu_store",  1'b1, F3_BU,  32'h10,   32'h11,   32'h0, 1'b1);
        xact("lw_10_keep2",1'b0, F3_W,   32'h10,   32'h0,    32'hDEADBEEF, 1'b0);

        // backpressure
        rsp_ready = 1'b0;
        issue("bp_lw", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_BU; req_addr = 32'h13;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp_err",   {31'b0, rsp_err}, 32'd0);
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        xact("bp_next_lbu", 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);

        // partial stores
        xact("sb_11",   1'b1, F3_B, 32'h11, 32'h55,   32'h0, 1'b0);
        xact("lw_sb",   1'b0, F3_W, 32'h10, 32'h0,    32'hDEAD55EF, 1'b0);
        xact("sh_12",   1'b1, F3_H, 32'h12, 32'h1234, 32'h0, 1'b0);
        xact("lw_sh",   1'b0, F3_W, 32'h10, 32'h0,    32'h123455EF, 1'b0);

        // reset during WAIT discards the store
        xact("sw_20_zero", 1'b1, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);
        issue("sw_20_kill", 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        reset_l = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst_wait");
        @(posedge clk); #2;
        reset_l = 1'b1;
        prev_vld = 1'b0;
        xact("lw_20", 1'b0, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);

        // LATENCY 1 instance
        xact1("l1_sw", 1'b1, F3_W, 32'h40, 32'h89ABCDEF, 32'h0);
        xact1("l1_lw", 1'b0, F3_W, 32'h40, 32'h0, 32'h89ABCDEF);
        xact1("l1_lh", 1'b0, F3_H, 32'h42, 32'h0, 32'hFFFF89AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a valid/ready handshake and applies RISC-V byte/half/word lane alignment.
- Stores into an internal word-organised RAM. Returns sign- or zero-extended load data after a fixed, programmable latency.
- Replaces the zero-wait data_mem when the core moves to a handshaked, multi-cycle memory interface.

Parameters:
- ADDR_WIDTH, 10, word-index bits; DEPTH = 2**ADDR_WIDTH 32-bit words, byte range 0 .. 4*DEPTH-1
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset_l  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32  store data, right-justified, unshifted
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no side effect

Behaviour:
- Reset: one clock, synchronous, active-low.
  - While reset_l = 0: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - At the next edge: state ← IDLE, latency counter ← 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1.
  - Accept on req_valid && req_ready at edge T0.
  - Capture we/addr/funct3/wdata. Inputs may change after T0.
  - Load counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready = 0.
  - Decrement the counter each edge.
  - At the edge where counter == 0: perform the access (commit the store or sample the read), register rsp_rdata and rsp_err, and go to RESP.
  - rsp_valid therefore rises at edge T0+LATENCY.
- RESP: rsp_valid = 1, req_ready = 0.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE and drop rsp_valid, rsp_rdata and rsp_err to 0.
  - No same-cycle re-accept. Minimum request spacing is LATENCY+1 cycles.
- Error conditions. Any one of the following sets rsp_err = 1, blocks the write and returns rdata 0, with the same latency as a normal access:
  - H/HU with addr[0] = 1
  - W with addr[1:0] != 0
  - funct3 ∈ {011, 110, 111}
  - a store with funct3[2] = 1
  - addr >= 4*DEPTH
- Store lanes:
  - B writes the byte lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - W writes all four lanes.
  - Other lanes are preserved, using a byte-enabled RAM write.
- Load extract: shift the RAM word right by 8*addr[1:0] and take 8 or 16 bits.
  - Sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1.
  - W returns the word unchanged.
- Reset mid-operation:
  - In WAIT: an uncommitted store is discarded and RAM is unchanged.
  - In RESP: the pending response is dropped.
- req_valid while not IDLE is ignored and is not queued.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum {IDLE, WAIT, RESP}
  - a function returning "illegal funct3 for we"
- One combinational sub-module, dmem_lane_align:
  - inputs: addr[1:0], funct3, wdata, raw RAM word
  - outputs: 4-bit byte enable, shifted write word, extended load word, misalign flag
- The RAM array, counter and FSM stay in dmem_responder.

Test Plan:
- Word round trip:
  - sw 0xDEADBEEF @0x10, then lw @0x10 → rdata 0xDEADBEEF, err 0.
  - rsp_valid rises exactly LATENCY edges after acceptance, checked for LATENCY = 1 and 4.
- Load extension, after the word round trip:
  - lb @0x13 → 0xFFFFFFDE
  - lbu @0x13 → 0x000000DE
  - lh @0x12 → 0xFFFFDEAD
  - lhu @0x12 → 0x0000DEAD
  - lb @0x10 → 0xFFFFFFEF
- Partial stores, after the word round trip:
  - sb 0x55 @0x11 → lw @0x10 = 0xDEAD55EF
  - then sh 0x1234 @0x12 → lw @0x10 = 0x123455EF
- Errors:
  - lw @0x12 → err 1, rdata 0
  - sh 0xFFFF @0x11 → err 1, and a later lw @0x10 is unchanged
  - lw @0x1000 with ADDR_WIDTH 10 → err 1
- Backpressure: hold rsp_ready = 0 for 5 cycles with req_valid = 1.
  - rsp_valid, rsp_rdata and rsp_err stay stable; req_ready = 0.
  - The next request is accepted only after the response handshake.
- Reset during WAIT: @0x20 holds 0, then issue sw 0xCAFEF00D @0x20 and pulse reset_l low for 1 cycle during WAIT.
  - All outputs are 0 during reset.
  - A subsequent lw @0x20 → 0x00000000.
